button_debouncer: RTL and testbench

Conditions the raw mechanical push-button from the board pad into a clean, synchronous, debounced level plus single-cycle press and release pulses. Sits directly upstream of the LED colour controller and drives its `button` input, so the colour advances only on genuine, stable presses. Contains a two-flop synchroniser, a debounce counter and a four-state FSM.

---
 rtl/button_debouncer.sv | 166 ++++++++++++++++
 tb/tb_button_debouncer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button synchroniser, debouncer and press/release strobe generator
//
// Purpose:
//   Turns the raw, bouncing, asynchronous push-button pad into a clean
//   debounced level plus one-cycle press and release strobes for the LED
//   colour controller. A two-flop synchroniser feeds a four-state FSM
//   (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) that has a shared counter.
//
// Optional feature:
//   BUTTON_DEBOUNCER_AUTO_REPEAT_EN - when defined, holding the button in
//   HELD re-fires press_pulse after HOLD_CYCLES cycles and then every
//   REPEAT_CYCLES cycles. When undefined, each accepted press gives exactly
//   one press_pulse and HOLD_CYCLES/REPEAT_CYCLES have no effect.
//
// Ports:
//   clk           - single clock, rising edge
//   rst           - synchronous reset, active low (0 = reset)
//   button_raw    - asynchronous pad input, active high
//   button        - registered debounced level
//   press_pulse   - registered one-cycle strobe on accepted press (and repeat)
//   release_pulse - registered one-cycle strobe on accepted release

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } state_e;

  logic             sync1_q;
  logic             sync2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             button_q, button_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
  // Set once the initial hold delay has elapsed; counter then times repeats.
  logic             rep_q, rep_d;
`endif

  logic s;
  assign s = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    rep_d     = rep_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (s) state_d = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
        end
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
        // Firing at count LAST makes the strobe visible on the following
        // cycle, i.e. HELD cycle HOLD_CYCLES and then every REPEAT_CYCLES.
        else if (rep_q ? (cnt_q == REP_LAST) : (cnt_q == HOLD_LAST)) begin
          press_d = 1'b1;
          rep_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_d = ST_HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every state entry starts a fresh count (and a fresh hold delay).
    if (state_d != state_q) begin
      cnt_d = '0;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
      rep_d = 1'b0;
`endif
    end

    // Level follows the next state so it rises/falls with the strobes.
    button_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      button_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
      rep_q     <= 1'b0;
`endif
    end else begin
      sync1_q   <= button_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      button_q  <= button_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign button        = button_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard testbench for button_debouncer

module tb_button_debouncer;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  logic clk        = 1'b0;
  logic rst        = 1'b0;
  logic button_raw = 1'b1;
  logic button;
  logic press_pulse;
  logic release_pulse;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button_raw   (button_raw),
    .button       (button),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  typedef struct packed {
    int   cyc;
    logic btn;
    logic prs;
    logic rls;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc      = 0;
  logic       rst_seen = 1'b0;
  logic [2:0] prev     = 3'b000;
  int         checks   = 0;
  int         errors   = 0;

  // Edge counter; rst_seen is the reset value the DUT sampled at this edge.
  always @(posedge clk) begin
    cyc      = cyc + 1;
    rst_seen = rst;
  end

  // Monitor: outputs must be zero after any reset edge; otherwise every
  // change of {button, press_pulse, release_pulse} is popped and compared.
  always @(negedge clk) begin : monitor
    logic [2:0] now_v;
    ev_t        e;
    now_v = {button, press_pulse, release_pulse};
    if (!rst_seen) begin
      checks = checks + 1;
      if (now_v !== 3'b000) begin
        errors = errors + 1;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=000", cyc, now_v);
      end
      prev = 3'b000;
    end else if (now_v !== prev) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_event cyc=%0d got=%b exp=none", cyc, now_v);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || {e.btn, e.prs, e.rls} !== now_v) begin
          errors = errors + 1;
          $display("FAIL event got cyc=%0d bits=%b exp cyc=%0d bits=%b",
                   cyc, now_v, e.cyc, {e.btn, e.prs, e.rls});
        end
      end
      prev = now_v;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic void push_ev(input int c, input logic b, input logic p, input logic r);
    ev_t e;
    e.cyc = c;
    e.btn = b;
    e.prs = p;
    e.rls = r;
    exp_q.push_back(e);
  endfunction

  function automatic void push_press(input int c);
    push_ev(c, 1'b1, 1'b1, 1'b0);
    push_ev(c + 1, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic void push_release(input int c);
    push_ev(c, 1'b0, 1'b0, 1'b1);
    push_ev(c + 1, 1'b0, 1'b0, 1'b0);
  endfunction

  // HELD entered at edge h; last is the final edge at which HELD still sees s=1.
  function automatic void push_held(input int h, input int last, input bit first);
    if (first) push_press(h);
    if (AR_EN) begin
      for (int k = HOLD; h + k <= last; k += REP) push_press(h + k);
    end
  endfunction

  task automatic release_btn(input int low);
    button_raw = 1'b0;
    push_release(cyc + 7);
    tick(low);
  endtask

  initial begin : stim
    int e;
    int f;

    // Reset for three edges with the button already pressed.
    rst        = 1'b0;
    button_raw = 1'b1;
    tick(3);

    // Reset released with button_raw still high: full debounce, one press.
    rst = 1'b1;
    e   = cyc;
    push_held(e + 7, e + 22, 1'b1);
    tick(20);
    release_btn(12);

    // Clean press held long enough for auto-repeat to cover HELD cycle 28.
    button_raw = 1'b1;
    e          = cyc;
    push_held(e + 7, e + 35, 1'b1);
    tick(33);
    release_btn(12);

    // Glitches of 3 and 4 cycles are rejected.
    button_raw = 1'b1;
    tick(3);
    button_raw = 1'b0;
    tick(10);
    button_raw = 1'b1;
    tick(4);
    button_raw = 1'b0;
    tick(10);

    // Shortest accepted press: 5 cycles.
    button_raw = 1'b1;
    e          = cyc;
    push_held(e + 7, e + 7, 1'b1);
    tick(5);
    release_btn(12);

    // Release bounce: 2 low cycles return to HELD silently, then a real release.
    button_raw = 1'b1;
    e          = cyc;
    push_held(e + 7, e + 12, 1'b1);
    tick(10);
    button_raw = 1'b0;
    f          = cyc;
    tick(2);
    button_raw = 1'b1;
    e          = cyc;
    push_held(f + 5, e + 22, 1'b0);
    tick(20);
    release_btn(10);

    // Reset mid-HELD: no release strobe, then re-press from reset.
    button_raw = 1'b1;
    e          = cyc;
    push_held(e + 7, e + 12, 1'b1);
    tick(12);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    e   = cyc;
    push_held(e + 7, e + 32, 1'b1);
    tick(30);
    release_btn(12);

    tick(5);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL leftover_events got=%0d exp=0 next_cyc=%0d", exp_q.size(), exp_q[0].cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
